// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the SRAM access arbiter.
// Holds the FSM state and requester encodings used by the arbiter.
package sram_arb_pkg;

  localparam int DEF_ADDR_W  = 20;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ACC_CYC = 2;
  localparam int ACC_CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_TURN = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_WRITE = 1'b0,
    REQ_READ  = 1'b1
  } requester_t;

  // Terminal value of the per-access beat counter.
  function automatic logic [ACC_CNT_W-1:0] last_beat(input int acc_cyc);
    return ACC_CNT_W'(acc_cyc - 1);
  endfunction

endpackage

// File: rtl/sram_access_arbiter.sv
// Time-shares one external SRAM between a write requester and a read requester,
// with fixed-length access cycles, a turnaround after writes and a write counter.
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ACC_CYC = DEF_ACC_CYC
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_clr_cnt,
  output logic [ADDR_W-1:0] o_wr_cnt,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_dq,
  output logic              o_sram_dq_oe,
  input  logic [DATA_W-1:0] i_sram_dq,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_ce_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);

  localparam logic [ACC_CNT_W-1:0] C_LAST = last_beat(ACC_CYC);

  arb_state_t             r_state;
  arb_state_t             w_state_next;
  requester_t             r_last;
  logic [ACC_CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic [DATA_W-1:0]      r_rd_data;
  logic                   r_rd_valid;
  logic [ADDR_W-1:0]      r_wr_cnt;

  logic w_rd_elig;
  logic w_grant_wr;
  logic w_grant_rd;
  logic w_beat_end;
  logic w_we_n;
  logic w_oe_n;
  logic w_dq_oe;
  logic w_wr_ack;
  logic w_idle;

  // A read that just completed is masked for one IDLE cycle so the requester
  // can drop its request in response to the valid pulse.
  assign w_idle     = (r_state == ST_IDLE);
  assign w_rd_elig  = i_rd_req & ~r_rd_valid;
  assign w_grant_wr = w_idle & i_wr_req & (~w_rd_elig | (r_last == REQ_READ));
  assign w_grant_rd = w_idle & w_rd_elig & ~w_grant_wr;
  assign w_beat_end = (r_cnt == C_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_we_n       = 1'b1;
    w_oe_n       = 1'b1;
    w_dq_oe      = 1'b0;
    w_wr_ack     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_wr) begin
          w_state_next = ST_WR;
        end else if (w_grant_rd) begin
          w_state_next = ST_RD;
        end
      end
      ST_WR: begin
        w_we_n  = 1'b0;
        w_dq_oe = 1'b1;
        if (w_beat_end) begin
          w_wr_ack     = 1'b1;
          w_state_next = ST_TURN;
        end
      end
      ST_RD: begin
        w_oe_n = 1'b0;
        if (w_beat_end) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_TURN: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if ((r_state == ST_WR || r_state == ST_RD) && !w_beat_end) begin
      r_cnt <= r_cnt + ACC_CNT_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  // SRAM pins come only from these registers, loaded at grant time.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_last  <= REQ_READ;
    end else if (w_grant_wr) begin
      r_addr  <= i_wr_addr;
      r_wdata <= i_wr_data;
      r_last  <= REQ_WRITE;
    end else if (w_grant_rd) begin
      r_addr  <= i_rd_addr;
      r_last  <= REQ_READ;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= (r_state == ST_RD) && w_beat_end;
      if ((r_state == ST_RD) && w_beat_end) begin
        r_rd_data <= i_sram_dq;
      end
    end
  end

  // A clear coinciding with an ack counts that ack, leaving the count at one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_cnt <= '0;
    end else if (w_wr_ack) begin
      if (i_clr_cnt) begin
        r_wr_cnt <= ADDR_W'(1);
      end else if (!(&r_wr_cnt)) begin
        r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
      end
    end else if (i_clr_cnt) begin
      r_wr_cnt <= '0;
    end
  end

  assign o_wr_ack     = w_wr_ack;
  assign o_rd_data    = r_rd_data;
  assign o_rd_valid   = r_rd_valid;
  assign o_wr_cnt     = r_wr_cnt;
  assign o_busy       = ~w_idle;
  assign o_sram_addr  = r_addr;
  assign o_sram_dq    = r_wdata;
  assign o_sram_dq_oe = w_dq_oe;
  assign o_sram_we_n  = w_we_n;
  assign o_sram_oe_n  = w_oe_n;
  assign o_sram_ce_n  = 1'b0;
  assign o_sram_lb_n  = 1'b0;
  assign o_sram_ub_n  = 1'b0;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Self-checking bench for sram_access_arbiter: a transaction-schedule model
// predicts every output each cycle, plus directed literal checks.
module tb_sram_access_arbiter;

  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int AC   = 2;
  localparam int MAXC = (1 << AW) - 1;

  logic          clk;
  logic          rst;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          clr;
  logic [DW-1:0] sram_din;

  logic          o_wr_ack;
  logic [DW-1:0] o_rd_data;
  logic          o_rd_valid;
  logic [AW-1:0] o_wr_cnt;
  logic          o_busy;
  logic [AW-1:0] o_sram_addr;
  logic [DW-1:0] o_sram_dq;
  logic          o_sram_dq_oe;
  logic          o_sram_we_n;
  logic          o_sram_oe_n;
  logic          o_sram_ce_n;
  logic          o_sram_lb_n;
  logic          o_sram_ub_n;

  int n_checks = 0;
  int n_err    = 0;

  sram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACC_CYC(AC)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(o_wr_ack),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .i_clr_cnt(clr), .o_wr_cnt(o_wr_cnt), .o_busy(o_busy),
    .o_sram_addr(o_sram_addr), .o_sram_dq(o_sram_dq), .o_sram_dq_oe(o_sram_dq_oe),
    .i_sram_dq(sram_din), .o_sram_we_n(o_sram_we_n), .o_sram_oe_n(o_sram_oe_n),
    .o_sram_ce_n(o_sram_ce_n), .o_sram_lb_n(o_sram_lb_n), .o_sram_ub_n(o_sram_ub_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External SRAM device: latches on clock while we_n is low, drives while oe_n low.
  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) sram_mem[i] = '0;
  always @(posedge clk) if (!o_sram_we_n) sram_mem[o_sram_addr] <= o_sram_dq;
  assign sram_din = o_sram_oe_n ? '0 : sram_mem[o_sram_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: per-cycle expectation schedule --------
  typedef struct packed {
    logic          busy;
    logic          we;
    logic          oe;
    logic          ack;
    logic          vld;
    logic [DW-1:0] rdat;
  } cyc_t;

  function automatic cyc_t mk(bit b, bit w, bit o, bit a, bit v, logic [DW-1:0] d);
    cyc_t c;
    c.busy = b; c.we = w; c.oe = o; c.ack = a; c.vld = v; c.rdat = d;
    return c;
  endfunction

  cyc_t          q[$];
  cyc_t          cur;
  bit            last_w;
  int            m_cnt;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_dq;
  logic [DW-1:0] m_rdat;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  task automatic m_reset();
    q.delete();
    cur    = mk(0, 0, 0, 0, 0, '0);
    last_w = 1'b0;
    m_cnt  = 0;
    m_addr = '0;
    m_dq   = '0;
    m_rdat = '0;
  endtask

  initial begin
    bit rd_ok;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_reset();
      end else begin
        if (cur.ack) m_cnt = clr ? 1 : ((m_cnt == MAXC) ? MAXC : m_cnt + 1);
        else if (clr) m_cnt = 0;
        if (q.size() == 0 && !cur.busy) begin
          rd_ok = rd_req && !cur.vld;
          if (wr_req && (!rd_ok || !last_w)) begin
            m_addr = wr_addr; m_dq = wr_data; ref_mem[wr_addr] = wr_data; last_w = 1'b1;
            for (int i = 0; i < AC; i++) q.push_back(mk(1, 1, 0, (i == AC - 1), 0, '0));
            q.push_back(mk(1, 0, 0, 0, 0, '0));
          end else if (rd_ok) begin
            m_addr = rd_addr; last_w = 1'b0;
            for (int i = 0; i < AC; i++) q.push_back(mk(1, 0, 1, 0, 0, '0));
            q.push_back(mk(0, 0, 0, 0, 1, ref_mem[rd_addr]));
          end
        end
        cur = (q.size() != 0) ? q.pop_front() : mk(0, 0, 0, 0, 0, '0);
        if (cur.vld) m_rdat = cur.rdat;
      end
    end
  end

  // Compare process: every output, every cycle, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("we_n",      o_sram_we_n,  !cur.we);
      chk("oe_n",      o_sram_oe_n,  !cur.oe);
      chk("dq_oe",     o_sram_dq_oe, cur.we);
      chk("wr_ack",    o_wr_ack,     cur.ack);
      chk("rd_valid",  o_rd_valid,   cur.vld);
      chk("busy",      o_busy,       cur.busy);
      chk("rd_data",   o_rd_data,    m_rdat);
      chk("wr_cnt",    o_wr_cnt,     m_cnt);
      chk("sram_addr", o_sram_addr,  m_addr);
      chk("sram_dq",   o_sram_dq,    m_dq);
      chk("tied_lo",   {o_sram_ce_n, o_sram_lb_n, o_sram_ub_n}, 3'b000);
    end
  end

  // Event monitor: pulse/strobe counters and grant order.
  int  we_low_n = 0, oe_low_n = 0, ack_n = 0, vld_n = 0;
  bit  rec = 1'b0;
  logic we_prev = 1'b1, oe_prev = 1'b1;
  byte ord_q[$];
  initial begin
    forever begin
      @(negedge clk);
      if (!o_sram_we_n) we_low_n++;
      if (!o_sram_oe_n) oe_low_n++;
      if (o_wr_ack) ack_n++;
      if (o_rd_valid) vld_n++;
      if (rec && !o_sram_we_n && we_prev) ord_q.push_back(8'h57);
      if (rec && !o_sram_oe_n && oe_prev) ord_q.push_back(8'h52);
      we_prev = o_sram_we_n;
      oe_prev = o_sram_oe_n;
    end
  end

  // ---------------- requester tasks (called on a falling edge) ---------------
  task automatic wait_ack();
    int t = 0;
    @(negedge clk);
    while (!o_wr_ack && t < 40) begin @(negedge clk); t++; end
    chk("wr_ack_seen", o_wr_ack, 1'b1);
  endtask

  task automatic wait_vld();
    int t = 0;
    @(negedge clk);
    while (!o_rd_valid && t < 40) begin @(negedge clk); t++; end
    chk("rd_valid_seen", o_rd_valid, 1'b1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit clr_at_ack);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    wait_ack();
    wr_req = 1'b0;
    if (clr_at_ack) begin
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    rd_req = 1'b1; rd_addr = a;
    wait_vld();
    rd_req = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------------------------------
  initial begin
    int  s_we, s_oe, s_ack, s_vld;
    byte exp_ord [4];
    exp_ord[0] = 8'h57; exp_ord[1] = 8'h52; exp_ord[2] = 8'h57; exp_ord[3] = 8'h52;
    rst = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0; clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we_n", o_sram_we_n, 1'b1);
    chk("rst_oe_n", o_sram_oe_n, 1'b1);
    chk("rst_dq_oe", o_sram_dq_oe, 1'b0);
    chk("rst_wr_cnt", o_wr_cnt, 0);
    chk("rst_pulses", {o_wr_ack, o_rd_valid}, 2'b00);
    rst = 1'b0;
    @(negedge clk);

    // Single write then read-back
    s_we = we_low_n; s_ack = ack_n;
    do_write(8'h10, 16'hBEEF, 1'b0);
    repeat (3) @(negedge clk);
    chk("wr_we_low_cycles", we_low_n - s_we, 2);
    chk("wr_ack_pulses", ack_n - s_ack, 1);
    chk("wr_cnt_after_1", o_wr_cnt, 1);
    chk("sram_cell_10", sram_mem[8'h10], 16'hBEEF);
    s_oe = oe_low_n; s_vld = vld_n;
    do_read(8'h10);
    chk("rd_data_beef", o_rd_data, 16'hBEEF);
    repeat (3) @(negedge clk);
    chk("rd_oe_low_cycles", oe_low_n - s_oe, 2);
    chk("rd_vld_pulses", vld_n - s_vld, 1);

    // Contested: both requesters held, expect W R W R
    rec = 1'b1;
    @(negedge clk);
    fork
      begin
        wr_req = 1'b1; wr_addr = 8'h20; wr_data = 16'h1111;
        wait_ack();
        wr_addr = 8'h21; wr_data = 16'h2222;
        wait_ack();
        wr_req = 1'b0;
      end
      begin
        rd_req = 1'b1; rd_addr = 8'h20;
        wait_vld();
        chk("contest_rd0", o_rd_data, 16'h1111);
        rd_addr = 8'h21;
        wait_vld();
        chk("contest_rd1", o_rd_data, 16'h2222);
        rd_req = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    rec = 1'b0;
    chk("order_len", ord_q.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("order%0d", i), ord_q[i], exp_ord[i]);
    chk("wr_cnt_after_3", o_wr_cnt, 3);

    // Reset during the first WR cycle
    s_ack = ack_n;
    wr_req = 1'b1; wr_addr = 8'h33; wr_data = 16'hDEAD;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_we_n", o_sram_we_n, 1'b1);
    chk("abort_busy", o_busy, 1'b0);
    chk("abort_wr_cnt", o_wr_cnt, 0);
    chk("abort_addr", o_sram_addr, 0);
    wr_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_ack", ack_n - s_ack, 0);
    chk("abort_cell_untouched", sram_mem[8'h33], 16'h0000);

    // Saturation of the write counter, then clear interactions
    for (int i = 0; i < MAXC; i++) do_write(AW'(i), DW'(i * 7 + 1), 1'b0);
    repeat (3) @(negedge clk);
    chk("cnt_at_max", o_wr_cnt, MAXC);
    do_write(8'h05, 16'h5555, 1'b0);
    repeat (3) @(negedge clk);
    chk("cnt_saturated", o_wr_cnt, MAXC);
    do_write(8'h06, 16'h6666, 1'b1);
    chk("cnt_clr_with_ack", o_wr_cnt, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("cnt_clr_alone", o_wr_cnt, 0);
    do_read(8'h06);
    chk("rd_data_6666", o_rd_data, 16'h6666);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
